// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU, with optional
// bounded ownership locking, carry chaining and a one-cycle registered response.
module alu_arbiter #(
  parameter int WORD_LEN = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic                lock0,
  input  logic                lock1,
  input  logic [3:0]          cmd0,
  input  logic [3:0]          cmd1,
  input  logic [WORD_LEN-1:0] a0,
  input  logic [WORD_LEN-1:0] b0,
  input  logic [WORD_LEN-1:0] a1,
  input  logic [WORD_LEN-1:0] b1,
  input  logic                cin0,
  input  logic                cin1,
  input  logic                chain0,
  input  logic                chain1,
  output logic                gnt0,
  output logic                gnt1,
  output logic [3:0]          alu_cmd,
  output logic [WORD_LEN-1:0] alu_val1,
  output logic [WORD_LEN-1:0] alu_val2,
  output logic                alu_cin,
  input  logic [WORD_LEN-1:0] alu_res,
  input  logic                alu_n,
  input  logic                alu_z,
  input  logic                alu_c,
  input  logic                alu_v,
  output logic                rsp_valid0,
  output logic                rsp_valid1,
  output logic [WORD_LEN-1:0] rsp_res,
  output logic [3:0]          rsp_flags,
  output logic                rsp_id
);

  localparam int CNT_W = $clog2(MAX_LOCK) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state, next_state;
  logic             prio, next_prio;
  logic [CNT_W-1:0] lock_cnt, next_cnt;
  logic             c_reg;
  logic             grant_any;
  logic             grant_id;
  logic             owner;
  logic             owner_lock;

  assign grant_any  = gnt0 | gnt1;
  assign grant_id   = gnt1;
  assign owner      = (state == OWN1);
  assign owner_lock = owner ? lock1 : lock0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= next_state;
      prio     <= next_prio;
      lock_cnt <= next_cnt;
    end
  end

  // Owner loses the lock on its own release, or is evicted after MAX_LOCK owned
  // cycles; only eviction hands priority to the other side.
  always_comb begin
    next_state = state;
    next_prio  = prio;
    next_cnt   = lock_cnt;
    case (state)
      IDLE: begin
        if (grant_any) begin
          next_prio = ~grant_id;
          if (grant_id ? lock1 : lock0) begin
            next_state = grant_id ? OWN1 : OWN0;
            next_cnt   = '0;
          end
        end
      end
      OWN0, OWN1: begin
        next_cnt = lock_cnt + 1'b1;
        if (!owner_lock) begin
          next_state = IDLE;
        end else if (lock_cnt == CNT_LAST) begin
          next_state = IDLE;
          next_prio  = ~owner;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            gnt0 = ~prio;
            gnt1 = prio;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        OWN0:    gnt0 = req0;
        OWN1:    gnt1 = req1;
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_cmd  = 4'b0000;
    alu_val1 = '0;
    alu_val2 = '0;
    alu_cin  = 1'b0;
    if (gnt1) begin
      alu_cmd  = cmd1;
      alu_val1 = a1;
      alu_val2 = b1;
      alu_cin  = chain1 ? c_reg : cin1;
    end else if (gnt0) begin
      alu_cmd  = cmd0;
      alu_val1 = a0;
      alu_val2 = b0;
      alu_cin  = chain0 ? c_reg : cin0;
    end
  end

  // Response and carry capture the ALU output at the edge closing a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_reg      <= 1'b0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_res    <= '0;
      rsp_flags  <= 4'b0000;
      rsp_id     <= 1'b0;
    end else begin
      rsp_valid0 <= gnt0;
      rsp_valid1 <= gnt1;
      if (grant_any) begin
        c_reg     <= alu_c;
        rsp_res   <= alu_res;
        rsp_flags <= {alu_n, alu_z, alu_c, alu_v};
        rsp_id    <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU drives alu_res/flags, a
// high-level arbitration model predicts grants, ALU operands and responses.
module tb_alu_arbiter;

  localparam int W  = 32;
  localparam int ML = 8;

  localparam logic [3:0] CMD_MOV = 4'd1;
  localparam logic [3:0] CMD_ADD = 4'd2;
  localparam logic [3:0] CMD_ADC = 4'd3;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, lock0, lock1;
  logic [3:0]   cmd0, cmd1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         cin0, cin1, chain0, chain1;
  logic         gnt0, gnt1;
  logic [3:0]   alu_cmd;
  logic [W-1:0] alu_val1, alu_val2;
  logic         alu_cin;
  logic [W-1:0] alu_res;
  logic         alu_n, alu_z, alu_c, alu_v;
  logic         rsp_valid0, rsp_valid1;
  logic [W-1:0] rsp_res;
  logic [3:0]   rsp_flags;
  logic         rsp_id;
  logic [35:0]  alu_out;

  int checks_total  = 0;
  int checks_passed = 0;

  // Model state: owner -1 means nobody holds the ALU.
  int           m_owner = -1;
  int           m_prio  = 0;
  int           m_cnt   = 0;
  int           m_gnt   = -1;
  bit           m_carry = 1'b0;
  bit           m_v0 = 1'b0, m_v1 = 1'b0, m_id = 1'b0;
  logic [W-1:0] m_res   = '0;
  logic [3:0]   m_flags = '0;
  logic [3:0]   e_cmd;
  logic [W-1:0] e_v1, e_v2;
  logic         e_cin;

  typedef struct {
    bit rst, req0, req1, lock0, lock1;
    bit gnt0, gnt1;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  alu_arbiter #(.WORD_LEN(W), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .cmd0(cmd0), .cmd1(cmd1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .cin0(cin0), .cin1(cin1), .chain0(chain0), .chain1(chain1),
    .gnt0(gnt0), .gnt1(gnt1),
    .alu_cmd(alu_cmd), .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags), .rsp_id(rsp_id)
  );

  // Result packed as {N, Z, C, V, res}.
  function automatic logic [35:0] alu_ref(input logic [3:0] cmd, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic cin);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (cmd)
      4'd1: r = y;
      4'd2: s = {1'b0, x} + {1'b0, y};
      4'd3: s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
      4'd4: s = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
      4'd5: r = x & y;
      4'd6: r = x | y;
      4'd7: r = x ^ y;
      default: r = '0;
    endcase
    if (cmd >= 4'd2 && cmd <= 4'd4) begin
      r = s[W-1:0];
      c = s[W];
      if (cmd == 4'd4) v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      else             v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {r[W-1], (r == '0), c, v, r};
  endfunction

  assign alu_out = alu_ref(alu_cmd, alu_val1, alu_val2, alu_cin);
  assign alu_res = alu_out[W-1:0];
  assign alu_n   = alu_out[35];
  assign alu_z   = alu_out[34];
  assign alu_c   = alu_out[33];
  assign alu_v   = alu_out[32];

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic apply_stimulus(input bit r, input bit q0, input bit q1, input bit l0, input bit l1);
    rst = r; req0 = q0; req1 = q1; lock0 = l0; lock1 = l1;
    cmd0 = 4'($urandom_range(0, 7)); cmd1 = 4'($urandom_range(0, 7));
    a0 = rand_word(); b0 = rand_word(); a1 = rand_word(); b1 = rand_word();
    cin0 = 1'($urandom_range(0, 1)); cin1 = 1'($urandom_range(0, 1));
    chain0 = 1'($urandom_range(0, 1)); chain1 = 1'($urandom_range(0, 1));
  endtask

  task automatic model_reset();
    m_owner = -1; m_prio = 0; m_cnt = 0; m_carry = 1'b0;
    m_v0 = 1'b0; m_v1 = 1'b0; m_id = 1'b0; m_res = '0; m_flags = '0;
  endtask

  // Predict this cycle's grant and ALU drive, then compare everything visible.
  task automatic settle();
    @(negedge clk);
    if (rst)                m_gnt = -1;
    else if (m_owner < 0)   m_gnt = (req0 && req1) ? m_prio : req0 ? 0 : req1 ? 1 : -1;
    else                    m_gnt = ((m_owner == 0) ? req0 : req1) ? m_owner : -1;
    e_cmd = '0; e_v1 = '0; e_v2 = '0; e_cin = 1'b0;
    if (m_gnt == 0) begin
      e_cmd = cmd0; e_v1 = a0; e_v2 = b0; e_cin = chain0 ? m_carry : cin0;
    end else if (m_gnt == 1) begin
      e_cmd = cmd1; e_v1 = a1; e_v2 = b1; e_cin = chain1 ? m_carry : cin1;
    end
    check_output("gnt0", gnt0, m_gnt == 0);
    check_output("gnt1", gnt1, m_gnt == 1);
    check_output("alu_cmd", alu_cmd, e_cmd);
    check_output("alu_val1", alu_val1, e_v1);
    check_output("alu_val2", alu_val2, e_v2);
    check_output("alu_cin", alu_cin, e_cin);
    check_output("rsp_valid0", rsp_valid0, m_v0);
    check_output("rsp_valid1", rsp_valid1, m_v1);
    check_output("rsp_res", rsp_res, m_res);
    check_output("rsp_flags", rsp_flags, m_flags);
    check_output("rsp_id", rsp_id, m_id);
  endtask

  task automatic advance();
    logic [35:0] r;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_gnt >= 0) begin
        r = alu_ref(e_cmd, e_v1, e_v2, e_cin);
        m_carry = r[33]; m_res = r[W-1:0]; m_flags = r[35:32];
        m_id = (m_gnt == 1); m_v0 = (m_gnt == 0); m_v1 = (m_gnt == 1);
      end else begin
        m_v0 = 1'b0; m_v1 = 1'b0;
      end
      if (m_owner < 0) begin
        if (m_gnt >= 0) begin
          m_prio = 1 - m_gnt;
          if ((m_gnt == 0) ? lock0 : lock1) begin
            m_owner = m_gnt; m_cnt = 0;
          end
        end
      end else if (!((m_owner == 0) ? lock0 : lock1)) begin
        m_owner = -1;
      end else if (m_cnt == ML - 1) begin
        m_prio = 1 - m_owner; m_owner = -1;
      end else begin
        m_cnt++;
      end
    end
    #1;
  endtask

  initial begin
    apply_stimulus(1, 0, 0, 0, 0);
    @(posedge clk);
    model_reset();
    #1;

    // Alternation, a forced lock eviction after 9 grants, and OWN1 exclusivity.
    tbl.push_back('{1, 1, 1, 0, 0, 0, 0});
    repeat (2) begin
      tbl.push_back('{0, 1, 1, 0, 0, 1, 0});
      tbl.push_back('{0, 1, 1, 0, 0, 0, 1});
    end
    repeat (9) tbl.push_back('{0, 1, 1, 1, 0, 1, 0});
    tbl.push_back('{0, 1, 1, 1, 0, 0, 1});
    tbl.push_back('{0, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 1, 0, 1, 0, 1});
    tbl.push_back('{0, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 1, 0, 1});
    tbl.push_back('{0, 1, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      apply_stimulus(tbl[i].rst, tbl[i].req0, tbl[i].req1, tbl[i].lock0, tbl[i].lock1);
      settle();
      check_output("tbl_gnt0", gnt0, tbl[i].gnt0);
      check_output("tbl_gnt1", gnt1, tbl[i].gnt1);
      advance();
    end

    // Carry chain across a locked pair of operations.
    apply_stimulus(1, 0, 0, 0, 0); settle(); advance();
    apply_stimulus(0, 1, 1, 1, 0);
    cmd0 = CMD_ADD; a0 = 32'hFFFF_FFFF; b0 = 32'h1; chain0 = 1'b0; cin0 = 1'b0;
    settle();
    check_output("chain_gnt0_first", gnt0, 1'b1);
    advance();
    apply_stimulus(0, 1, 1, 0, 0);
    cmd0 = CMD_ADC; a0 = '0; b0 = '0; chain0 = 1'b1;
    settle();
    check_output("chain_gnt1_blocked", gnt1, 1'b0);
    check_output("chain_cin", alu_cin, 1'b1);
    check_output("chain_rsp_valid0", rsp_valid0, 1'b1);
    check_output("chain_res_first", rsp_res, 32'h0);
    check_output("chain_flags_first", rsp_flags, 4'b0110);
    advance();
    apply_stimulus(0, 0, 1, 0, 0);
    settle();
    check_output("chain_gnt1_idle", gnt1, 1'b1);
    check_output("chain_res_second", rsp_res, 32'h1);
    check_output("chain_flags_second", rsp_flags, 4'b0000);
    check_output("chain_id_second", rsp_id, 1'b0);
    advance();

    // Single MOV from requester 1, then a quiet stretch holding its result.
    apply_stimulus(0, 0, 1, 0, 0);
    cmd1 = CMD_MOV; b1 = 32'h1234_5678;
    settle();
    check_output("mov_alu_cmd", alu_cmd, 4'b0001);
    advance();
    apply_stimulus(0, 0, 0, 0, 0);
    settle();
    check_output("mov_rsp_valid1", rsp_valid1, 1'b1);
    check_output("mov_rsp_valid0", rsp_valid0, 1'b0);
    check_output("mov_rsp_res", rsp_res, 32'h1234_5678);
    advance();
    repeat (5) begin
      apply_stimulus(0, 0, 0, 0, 0);
      settle();
      check_output("quiet_alu_cmd", alu_cmd, 4'b0000);
      check_output("quiet_alu_val1", alu_val1, 32'h0);
      check_output("quiet_alu_val2", alu_val2, 32'h0);
      check_output("quiet_rsp_valid1", rsp_valid1, 1'b0);
      check_output("quiet_rsp_res", rsp_res, 32'h1234_5678);
      advance();
    end

    // Reset while requester 1 owns the ALU.
    apply_stimulus(0, 0, 1, 0, 1); settle(); advance();
    apply_stimulus(1, 0, 1, 0, 1);
    settle();
    check_output("rst_gnt1_gated", gnt1, 1'b0);
    advance();
    apply_stimulus(0, 1, 1, 0, 0);
    settle();
    check_output("post_rst_valid0", rsp_valid0, 1'b0);
    check_output("post_rst_valid1", rsp_valid1, 1'b0);
    check_output("post_rst_gnt0", gnt0, 1'b1);
    advance();
    apply_stimulus(0, 1, 1, 0, 0);
    settle();
    check_output("post_rst_gnt1", gnt1, 1'b1);
    advance();

    for (int n = 0; n < 800; n++) begin
      apply_stimulus($urandom_range(0, 59) == 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WORD_LEN, default 32: operand/result width.
REQ-002 Parameter MAX_LOCK, default 8: maximum consecutive owned cycles after a locking grant.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 reqN  input  1  requester N (N=0,1) wants one ALU operation this cycle.
REQ-006 lockN  input  1  requester N keeps ALU ownership after this grant.
REQ-007 cmdN  input  4  ALU command code for requester N.
REQ-008 aN, bN  input  WORD_LEN each  Val1/Val2 operands for requester N.
REQ-009 cinN  input  1  carry-in for requester N.
REQ-010 chainN  input  1  use registered carry of previous issued op instead of cinN.
REQ-011 gntN  output  1  combinational grant to requester N this cycle.
REQ-012 alu_cmd  output  4  command to shared ALU.
REQ-013 alu_val1, alu_val2  output  WORD_LEN each  operands to shared ALU.
REQ-014 alu_cin  output  1  carry-in to shared ALU.
REQ-015 alu_res  input  WORD_LEN  ALU combinational result.
REQ-016 alu_n, alu_z, alu_c, alu_v  input  1 each  ALU combinational flags.
REQ-017 rsp_validN  output  1  one-cycle pulse: requester N's result is on rsp_res/rsp_flags.
REQ-018 rsp_res  output  WORD_LEN  registered result.
REQ-019 rsp_flags  output  4  registered {N,Z,C,V}.
REQ-020 rsp_id  output  1  requester index of current response.

Function
REQ-021 Internal state SHALL be IDLE, OWN0 or OWN1, plus priority bit prio, carry register c_reg and counter lock_cnt (width clog2(MAX_LOCK)+1).
REQ-022 IDLE: single requester is granted; both requesting -> grant requester indexed by prio; prio then SHALL become the non-granted index; no request -> prio unchanged.
REQ-023 IDLE grant with lockN=1 SHALL move to OWNN and clear lock_cnt; otherwise stay IDLE.
REQ-024 OWNN: only requester N SHALL be granted (when reqN=1); other requester's gntN SHALL be 0 regardless of its req.
REQ-025 OWNN: lock_cnt increments every cycle; exit to IDLE when lockN=0 in a cycle (granted or not), or when lock_cnt==MAX_LOCK-1 (that cycle still grants N), whichever first.
REQ-026 Forced exit on lock_cnt limit SHALL set prio to the other requester; voluntary exit leaves prio unchanged.
REQ-027 OWNN with reqN=0 and lockN=1: no issue, ALU outputs idle, state held (counter still advances).
REQ-028 At most one gnt SHALL be high per cycle; gnt SHALL never assert when rst=1.
REQ-029 Granted cycle: alu_cmd/val1/val2 = granted cmd/a/b; alu_cin = chainN ? c_reg : cinN.
REQ-030 No grant: alu_cmd=4'b0000, alu_val1=alu_val2=0, alu_cin=0.
REQ-031 On each granted edge c_reg SHALL load alu_c; otherwise hold.
REQ-032 Latency 1: at the edge ending a granted cycle, rsp_res<=alu_res, rsp_flags<={alu_n,alu_z,alu_c,alu_v}, rsp_id<=N, rsp_validN<=1; rsp_valid of the other requester 0.
REQ-033 Cycle after a non-granted cycle: both rsp_valid 0; rsp_res/rsp_flags/rsp_id hold last values.
REQ-034 Back-to-back grants SHALL produce back-to-back responses, no bubble; no backpressure on responses.

Reset
REQ-035 rst=1 at an edge: state IDLE, prio=0, c_reg=0, lock_cnt=0, rsp_valid0/1=0, rsp_res=0, rsp_flags=0, rsp_id=0.
REQ-036 Reset during OWNN or with an op in flight SHALL drop ownership and the pending response (no rsp_valid in the cycle after reset).

Verification
REQ-037 Both req, lock=0, after reset -> grants alternate 0,1,0,1; rsp_id follows 1 cycle later, one rsp_valid per cycle.
REQ-038 Req0 ADD a0=0xFFFFFFFF,b0=1,lock0=1, next cycle ADC a0=0,b0=0,chain0=1,lock0=0 -> rsp 0x00000000 flags C=1 Z=1, then rsp 0x00000001; req1 held high gets no grant until state IDLE.
REQ-039 Req0 lock0 held 1 forever with req1=1, MAX_LOCK=8 -> gnt0 for 9 consecutive cycles, then gnt1; prio=0 afterwards in IDLE ties resolved per REQ-022.
REQ-040 Single req1 MOV b1=0x12345678 -> alu_cmd=0001 same cycle, rsp_valid1=1 rsp_res=0x12345678 next cycle, rsp_valid0=0.
REQ-041 rst asserted in OWN1 with grant active -> next cycle rsp_valid0/1=0, gnt follows IDLE rules, prio=0.
REQ-042 No requests for 5 cycles -> alu_cmd=0000, operands 0, rsp_valid low, rsp_res holding prior value.
